pipe_downsizer: RTL and testbench
=================================

# pipe_downsizer

Stream width down-converter. Sits at the consumer end of a fully-registered valid/ready pipe. Accepts one wide word per upstream handshake and replays it as `WIDTH_IN/WIDTH_OUT` narrow beats, least-significant lane first, with a last-beat marker. Sustains one output beat per cycle with no bubbles between words.

## Interface
- `WIDTH_IN`, default 512: upstream word width.
- `WIDTH_OUT`, default 64: downstream beat width. `RATIO = WIDTH_IN/WIDTH_OUT` must be an integer ≥ 2; any other value is an elaboration error.
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `us_valid` in 1: upstream word valid.
- `us_data` in WIDTH_IN: upstream word.
- `us_ready` out 1: block can accept a word this cycle.
- `ds_valid` out 1: downstream beat valid.
- `ds_data` out WIDTH_OUT: downstream beat.
- `ds_last` out 1: current beat is lane RATIO-1 of its word.
- `ds_ready` in 1: downstream accepts the beat.

## Operation
- State: `IDLE` / `EMIT`; holding register `hold_q[WIDTH_IN]`; lane counter `cnt_q`, width `$clog2(RATIO)`.
- `IDLE`: `us_ready=1`, `ds_valid=0`. On `us_valid&&us_ready`: `hold_q<=us_data`, `cnt_q<=0`, go to `EMIT`.
- `EMIT`:
  - `ds_valid=1`.
  - `ds_data=hold_q[cnt_q*WIDTH_OUT +: WIDTH_OUT]`.
  - `ds_last=(cnt_q==RATIO-1)`.
- Beat handshake (`ds_valid&&ds_ready`) with `cnt_q<RATIO-1`: `cnt_q<=cnt_q+1`.
- Handshake on the last beat:
  - If `us_valid` is also high in the same cycle: load the new word, `cnt_q<=0`, stay in `EMIT`.
  - Otherwise: go to `IDLE`.
- `us_ready = (state==IDLE) || (cnt_q==RATIO-1 && ds_ready)`. This is the only combinational ready path.
- `ds_ready` low: `ds_data`, `ds_last` and `cnt_q` hold. Beats are never dropped or duplicated.
- `ds_valid`, once asserted, stays high until its handshake (no retraction).
- `us_ready` is forced to 0 while `rst` is high. Handshakes are ignored during reset.

## Timing
- Reset values, asynchronous on `rst` assertion:
  - state `IDLE`, `cnt_q=0`, `hold_q=0`.
  - `ds_valid=0`, `ds_last=0`, `ds_data=0`, `us_ready=0`.
- After `rst` deasserts: `us_ready=1` in the first cycle.
- Latency: upstream handshake at edge N → first beat valid after edge N (cycle N+1).
- Throughput with `ds_ready` held at 1: RATIO beats per word. The next word's lane 0 follows lane RATIO-1 on the very next cycle.
- Reset mid-word: remaining lanes are discarded. The first word after reset starts at lane 0.
- `RATIO` a power of two: `cnt_q` wraps naturally. Otherwise the counter is explicitly compared to RATIO-1 and never exceeds it.

## Configuration
- `PIPE_DOWNSIZER_OUT_REG_EN` defined:
  - `ds_valid`, `ds_data` and `ds_last` pass through one `pipe_adapter` of width `WIDTH_OUT+1` (data plus last) before the ports.
  - All downstream outputs come straight from flops.
  - Latency becomes 2 cycles.
  - Full throughput is preserved.
  - The internal ready term uses the slice's upstream ready in place of `ds_ready`.
  - Reset values are unchanged.
- Not defined: outputs come directly from the lane mux as described above, with 1-cycle latency.

## Test plan
Parameters for all scenarios: WIDTH_IN=512, WIDTH_OUT=64, RATIO=8.
- **Single word:** lane k = `64'h(k+1)`, `ds_ready=1` → beats 1..8 on 8 consecutive cycles. `ds_last` high only on beat 8. Then `IDLE`, `us_ready=1`.
- **Back-to-back:** two words (lanes 1..8, then 9..16), `us_valid` held, `ds_ready=1` → 16 beats in 16 consecutive cycles. `us_ready` high only in the lane-8 cycle. No bubble.
- **Backpressure:** drop `ds_ready` for 5 cycles while beat 3 is presented → `ds_data=3` stable, `cnt_q` held. Beats 4..8 follow, no loss or duplicate.
- **Reset mid-word:** assert `rst` after beat 4 → `ds_valid=0` immediately. After release, a new word (lanes `A0..A7`) emits `A0` first.
- **Ready gating:** `us_valid=1` while in `EMIT` at lane 2 with `ds_ready=1` → `us_ready=0` until the lane-8 cycle, then the word is accepted.
- **`PIPE_DOWNSIZER_OUT_REG_EN` defined:** rerun the single-word and back-to-back scenarios → first beat arrives 2 cycles after the handshake, identical beat sequence, 16 beats in 16 consecutive cycles.

Source files
------------

// File: rtl/pipe_downsizer.sv
// Wide-to-narrow stream converter: one WIDTH_IN word in, WIDTH_IN/WIDTH_OUT beats out, lane 0 first.
// Define PIPE_DOWNSIZER_OUT_REG_EN to put a registered skid slice (pipe_adapter) on the downstream port.

`ifdef PIPE_DOWNSIZER_OUT_REG_EN
module pipe_adapter #(
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             s_ready,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready
);
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;

    // s_ready depends only on the skid flop, so nothing combinational crosses the slice
    assign s_ready = !skid_valid_q;
    assign m_valid = out_valid_q;
    assign m_data  = out_data_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!out_valid_q || m_ready) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = s_valid;
                if (s_valid) begin
                    out_data_d = s_data;
                end
            end
        end else if (s_valid && s_ready) begin
            skid_valid_d = 1'b1;
            skid_data_d  = s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end
endmodule
`endif

module pipe_downsizer #(
    parameter int WIDTH_IN  = 512,
    parameter int WIDTH_OUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 us_valid,
    input  logic [WIDTH_IN-1:0]  us_data,
    output logic                 us_ready,
    output logic                 ds_valid,
    output logic [WIDTH_OUT-1:0] ds_data,
    output logic                 ds_last,
    input  logic                 ds_ready
);
    localparam int RATIO = WIDTH_IN / WIDTH_OUT;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

    generate
        if (RATIO < 2 || RATIO * WIDTH_OUT != WIDTH_IN) begin : g_bad_ratio
            $error("pipe_downsizer: WIDTH_IN must be an integer multiple (>=2) of WIDTH_OUT");
        end
    endgenerate

    typedef enum logic {
        S_IDLE,
        S_EMIT
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WIDTH_IN-1:0]   hold_q, hold_d;

    logic [WIDTH_OUT-1:0]  lanes [RATIO];
    logic                  emit_valid;
    logic                  emit_last;
    logic [WIDTH_OUT-1:0]  emit_data;
    logic                  int_ready;
    logic                  us_hs;
    logic                  beat_hs;

    for (genvar i = 0; i < RATIO; i++) begin : g_lane
        assign lanes[i] = hold_q[i*WIDTH_OUT +: WIDTH_OUT];
    end

    assign emit_valid = (state_q == S_EMIT);
    assign emit_last  = emit_valid && (cnt_q == LAST_LANE);
    assign emit_data  = lanes[cnt_q];

    // Only combinational ready path: a new word may land in the same cycle the last lane leaves
    assign us_ready = !rst && ((state_q == S_IDLE) || ((cnt_q == LAST_LANE) && int_ready));
    assign us_hs    = us_valid && us_ready;
    assign beat_hs  = emit_valid && int_ready;

`ifdef PIPE_DOWNSIZER_OUT_REG_EN
    logic                 slice_s_ready;
    logic [WIDTH_OUT:0]   slice_m_data;

    pipe_adapter #(
        .WIDTH (WIDTH_OUT + 1)
    ) u_out_slice (
        .clk     (clk),
        .rst     (rst),
        .s_valid (emit_valid),
        .s_data  ({emit_last, emit_data}),
        .s_ready (slice_s_ready),
        .m_valid (ds_valid),
        .m_data  (slice_m_data),
        .m_ready (ds_ready)
    );

    assign int_ready = slice_s_ready;
    assign ds_last   = slice_m_data[WIDTH_OUT];
    assign ds_data   = slice_m_data[WIDTH_OUT-1:0];
`else
    assign int_ready = ds_ready;
    assign ds_valid  = emit_valid;
    assign ds_last   = emit_last;
    assign ds_data   = emit_data;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        case (state_q)
            S_IDLE: begin
                if (us_hs) begin
                    hold_d  = us_data;
                    cnt_d   = '0;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (beat_hs) begin
                    if (cnt_q != LAST_LANE) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (us_hs) begin
                        hold_d = us_data;
                        cnt_d  = '0;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end
endmodule

// File: tb/tb_pipe_downsizer.sv
// Directed + randomized bench for pipe_downsizer; expected beats come from a word-level lane model.
// Honours PIPE_DOWNSIZER_OUT_REG_EN for the expected latency.

module tb_pipe_downsizer;
    localparam int WI = 512;
    localparam int WO = 64;
    localparam int R  = WI / WO;
`ifdef PIPE_DOWNSIZER_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk;
    logic          rst;
    logic          us_valid;
    logic [WI-1:0] us_data;
    logic          us_ready;
    logic          ds_valid;
    logic [WO-1:0] ds_data;
    logic          ds_last;
    logic          ds_ready;

    typedef struct {
        logic [WO-1:0] d;
        logic          l;
        logic          ur;
        int            c;
    } beat_t;

    beat_t got[$];
    beat_t exp_q[$];
    int    hs_cyc[$];
    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;

    logic          pv = 1'b0;
    logic          pr = 1'b0;
    logic [WO-1:0] pd = '0;

    pipe_downsizer #(.WIDTH_IN(WI), .WIDTH_OUT(WO)) dut (
        .clk      (clk),
        .rst      (rst),
        .us_valid (us_valid),
        .us_data  (us_data),
        .us_ready (us_ready),
        .ds_valid (ds_valid),
        .ds_data  (ds_data),
        .ds_last  (ds_last),
        .ds_ready (ds_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk_int(input string tag, input integer obs, input integer expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [WO-1:0] obs, input logic [WO-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Observe accepted beats and verify stalled beats are held unchanged
    always @(negedge clk) begin
        if (rst) begin
            pv <= 1'b0;
            pr <= 1'b0;
        end else begin
            if (pv && !pr) begin
                chk_int("hold_valid", 32'(ds_valid), 1);
                chk_vec("hold_data", ds_data, pd);
            end
            if (ds_valid && ds_ready)
                got.push_back(beat_t'{ds_data, ds_last, us_ready, cyc});
            pv <= ds_valid;
            pr <= ds_ready;
            pd <= ds_data;
        end
    end

    function automatic logic [WO-1:0] lane_of(input logic [WI-1:0] w, input int k);
        logic [WI-1:0] t;
        t = w >> (k * WO);
        return t[WO-1:0];
    endfunction

    function automatic logic [WI-1:0] rand_word();
        logic [WI-1:0] w;
        w = '0;
        for (int k = 0; k < WI / 32; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [WI-1:0] count_word(input int base);
        logic [WI-1:0] w;
        w = '0;
        for (int k = 0; k < R; k++) w = w | (WI'(base + k) << (k * WO));
        return w;
    endfunction

    task automatic model_word(input logic [WI-1:0] w);
        for (int k = 0; k < R; k++)
            exp_q.push_back(beat_t'{lane_of(w, k), (k == R - 1), (k == R - 1), 0});
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [WI-1:0] w, input int budget);
        bit ok;
        ok = 0;
        us_data  = w;
        us_valid = 1'b1;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (us_ready) begin
                ok = 1;
                hs_cyc.push_back(cyc);
            end
        end
        sync();
        chk_int("send_accept", 32'(ok), 1);
        if (ok) model_word(w);
    endtask

    task automatic wait_beats(input int n, input int budget);
        for (int i = 0; i < budget && got.size() < n; i++) sync();
        chk_int("beat_count", got.size(), n);
    endtask

    task automatic compare_all(input string tag, input bit strict);
        repeat (4) sync();
        chk_int({tag, "_size"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            chk_vec({tag, "_data"}, got[i].d, exp_q[i].d);
            chk_int({tag, "_last"}, 32'(got[i].l), 32'(exp_q[i].l));
`ifndef PIPE_DOWNSIZER_OUT_REG_EN
            chk_int({tag, "_usready"}, 32'(got[i].ur), 32'(exp_q[i].ur));
`endif
            if (strict && i > 0)
                chk_int({tag, "_gap"}, got[i].c - got[i-1].c, 1);
        end
        if (strict && got.size() > 0 && hs_cyc.size() > 0)
            chk_int({tag, "_latency"}, got[0].c - hs_cyc[0], LAT);
        got.delete();
        exp_q.delete();
        hs_cyc.delete();
    endtask

    initial begin
        logic [WI-1:0] wa;
        logic [WI-1:0] wb;
        bit            sent_all;

        rst      = 1'b1;
        us_valid = 1'b0;
        us_data  = '0;
        ds_ready = 1'b0;
        repeat (3) sync();
        chk_int("rst_ds_valid", 32'(ds_valid), 0);
        chk_int("rst_ds_last", 32'(ds_last), 0);
        chk_vec("rst_ds_data", ds_data, '0);
        chk_int("rst_us_ready", 32'(us_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        chk_int("post_rst_us_ready", 32'(us_ready), 1);
        chk_int("post_rst_ds_valid", 32'(ds_valid), 0);
        sync();
        ds_ready = 1'b1;

        // single word, lanes 1..8
        send_word(count_word(1), 20);
        us_valid = 1'b0;
        wait_beats(R, 40);
        compare_all("single", 1);
        @(negedge clk);
        chk_int("single_idle_us_ready", 32'(us_ready), 1);
        chk_int("single_idle_ds_valid", 32'(ds_valid), 0);
        sync();

        // back-to-back words with us_valid held
        send_word(count_word(1), 20);
        send_word(count_word(R + 1), 40);
        us_valid = 1'b0;
        wait_beats(2 * R, 80);
        compare_all("b2b", 1);

        // backpressure while beat 3 is presented
        wa = rand_word();
        send_word(wa, 20);
        us_valid = 1'b0;
        wait_beats(2, 40);
        ds_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk_vec("bp_data", ds_data, lane_of(wa, 2));
            chk_int("bp_valid", 32'(ds_valid), 1);
            chk_int("bp_last", 32'(ds_last), 0);
        end
        sync();
        ds_ready = 1'b1;
        wait_beats(R, 40);
        compare_all("bp", 0);

        // reset mid-word
        wa = rand_word();
        send_word(wa, 20);
        us_valid = 1'b0;
        wait_beats(4, 40);
        rst = 1'b1;
        #1;
        chk_int("midrst_ds_valid", 32'(ds_valid), 0);
        chk_int("midrst_us_ready", 32'(us_ready), 0);
        chk_int("midrst_ds_last", 32'(ds_last), 0);
        chk_vec("midrst_ds_data", ds_data, '0);
        got.delete();
        exp_q.delete();
        hs_cyc.delete();
        repeat (2) sync();
        rst = 1'b0;
        @(negedge clk);
        chk_int("midrst_release_us_ready", 32'(us_ready), 1);
        sync();
        wa = rand_word();
        send_word(wa, 20);
        us_valid = 1'b0;
        wait_beats(R, 40);
        compare_all("after_rst", 1);

        // ready gating: second word offered during lane 2 of the first
        wa = rand_word();
        wb = rand_word();
        send_word(wa, 20);
        us_valid = 1'b0;
        wait_beats(1, 40);
        send_word(wb, 40);
        us_valid = 1'b0;
        chk_int("gate_accept_gap", (hs_cyc.size() == 2) ? hs_cyc[1] - hs_cyc[0] : -1, R);
        wait_beats(2 * R, 80);
        compare_all("gating", 1);

        // random words under random backpressure
        sent_all = 0;
        fork
            begin
                for (int n = 0; n < 6; n++) begin
                    send_word(rand_word(), 200);
                    us_valid = 1'b0;
                    repeat ($urandom_range(0, 2)) sync();
                end
                sent_all = 1;
            end
            begin
                for (int i = 0; i < 2000 && !sent_all; i++) begin
                    ds_ready = 1'($urandom_range(0, 1));
                    sync();
                end
            end
        join
        ds_ready = 1'b1;
        wait_beats(6 * R, 200);
        compare_all("random", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
